// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : 2-entry skid-buffered pipeline register (ctrl + data words)
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 5,
   parameter int CTRL_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [CTRL_WIDTH-1:0]           in_ctrl,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
   input  logic                            flush,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [CTRL_WIDTH-1:0]           out_ctrl,
   output logic [NUM_WORDS*DATA_WIDTH-1:0] out_data,
   output logic [1:0]                      occupancy,
   output logic [CNT_WIDTH-1:0]            stall_cycles
);

   localparam int c_DW = NUM_WORDS * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_out_valid;
   logic                   r_in_ready;
   logic [1:0]             r_occ;
   logic [1:0]             w_next_occ;
   logic [CTRL_WIDTH-1:0]  r_main_ctrl;
   logic [c_DW-1:0]        r_main_data;
   logic [CTRL_WIDTH-1:0]  r_skid_ctrl;
   logic [c_DW-1:0]        r_skid_data;
   logic [CNT_WIDTH-1:0]   r_stall;
   logic                   w_in_fire;
   logic                   w_out_fire;
   logic                   w_load_main;
   logic                   w_main_from_skid;
   logic                   w_load_skid;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occ       <= 2'd0;
      end else begin
         r_state     <= w_next_state;
         r_out_valid <= (w_next_state != S_EMPTY);
         r_in_ready  <= (w_next_state != S_TWO);
         r_occ       <= w_next_occ;
      end
   end

   // Flush wins over every other event and suppresses all loads.
   always_comb begin
      w_next_state     = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_next_state = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_load_main  = 1'b1;
                  w_next_state = S_ONE;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_main = 1'b1;
               end else if (w_in_fire) begin
                  w_load_skid  = 1'b1;
                  w_next_state = S_TWO;
               end else if (w_out_fire) begin
                  w_next_state = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_out_fire) begin
                  w_load_main      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_next_state     = S_ONE;
               end
            end
            default: w_next_state = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      w_next_occ = 2'd0;
      case (w_next_state)
         S_ONE:   w_next_occ = 2'd1;
         S_TWO:   w_next_occ = 2'd2;
         default: w_next_occ = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_load_main) begin
            r_main_ctrl <= w_main_from_skid ? r_skid_ctrl : in_ctrl;
            r_main_data <= w_main_from_skid ? r_skid_data : in_data;
         end
         if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
         end
      end
   end

   // Saturating stall counter; deliberately independent of flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall <= '0;
      end else if (r_out_valid && !out_ready && (r_stall != {CNT_WIDTH{1'b1}})) begin
         r_stall <= r_stall + CNT_WIDTH'(1);
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_ctrl     = r_out_valid ? r_main_ctrl : '0;
   assign out_data     = r_main_data;
   assign occupancy    = r_occ;
   assign stall_cycles = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus a randomized run against a queue model.
`default_nettype none

module tb_pipe_stage_reg;

   localparam int DW = 64;
   localparam int NW = 3;
   localparam int CW = 16;
   localparam int KW = 16;
   localparam int TW = DW * NW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [TW-1:0] in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [TW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [KW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [TW-1:0] d;
   } ent_t;

   ent_t        q[$];
   int unsigned m_stall = 0;

   pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CTRL_WIDTH(CW), .CNT_WIDTH(KW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [TW-1:0] rand_data();
      logic [TW-1:0] v;
      v = '0;
      for (int i = 0; i < TW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Advance one clock edge, updating the FIFO model from the inputs presented before it.
   task automatic tick();
      bit fi, fo;
      fi = in_valid && (q.size() < 2);
      fo = (q.size() > 0) && out_ready;
      @(posedge clk);
      if ((q.size() > 0) && !out_ready && (m_stall < 65535)) m_stall++;
      if (flush) begin
         q.delete();
      end else begin
         if (fo) void'(q.pop_front());
         if (fi) q.push_back('{c: in_ctrl, d: in_data});
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 ||
          stall_cycles !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: v=%b ctrl=%h data=%h occ=%0d stall=%0d rdy=%b, required 0/0/0/0/0/1",
                  out_valid, out_ctrl, out_data, occupancy, stall_cycles, in_ready);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_first();
      in_valid = 1'b1; in_ctrl = 16'h00A5; in_data = '0; in_data[DW-1:0] = 64'h1000; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h00A5 || out_data[DW-1:0] !== 64'h1000 || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL first: v=%b ctrl=%h w0=%h occ=%0d, required 1/00a5/1000/1",
                  out_valid, out_ctrl, out_data[DW-1:0], occupancy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL drain: v=%b ctrl=%h occ=%0d, required 0/0/0", out_valid, out_ctrl, occupancy);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 16'd1; in_data = rand_data(); tick();
      in_ctrl = 16'd2; in_data = rand_data(); tick();
      checks++;
      if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_ctrl !== 16'd1) begin
         errors++;
         $display("FAIL full: rdy=%b occ=%0d ctrl=%h, required 0/2/1", in_ready, occupancy, out_ctrl);
      end
      in_ctrl = 16'd3; in_data = rand_data(); tick();
      checks++;
      if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_ctrl !== 16'd1) begin
         errors++;
         $display("FAIL held_upstream: rdy=%b occ=%0d ctrl=%h, required 0/2/1", in_ready, occupancy, out_ctrl);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'd2) begin
         errors++;
         $display("FAIL order2: v=%b ctrl=%h, required 1/2", out_valid, out_ctrl);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'd3) begin
         errors++;
         $display("FAIL order3: v=%b ctrl=%h, required 1/3", out_valid, out_ctrl);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL order_end: v=%b occ=%0d, required 0/0", out_valid, occupancy);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 16'h0011; in_data = rand_data(); tick();
      in_ctrl = 16'h0022; in_data = rand_data(); tick();
      flush = 1'b1; in_ctrl = 16'h0077; in_data = rand_data();
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush: v=%b ctrl=%h occ=%0d rdy=%b, required 0/0/0/1",
                  out_valid, out_ctrl, occupancy, in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            errors++;
            $display("FAIL flush_ghost: v=%b ctrl=%h, required 0/0", out_valid, out_ctrl);
         end
      end
   endtask

   task automatic test_random();
      int pushed, popped;
      pushed = 0; popped = 0;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_ctrl   = 16'($urandom);
         in_data   = rand_data();
         checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
             occupancy !== 2'(q.size()) || stall_cycles !== KW'(m_stall) ||
             (q.size() > 0 && (out_ctrl !== q[0].c || out_data !== q[0].d)) ||
             (q.size() == 0 && out_ctrl !== '0)) begin
            errors++;
            $display("FAIL random[%0d]: v=%b rdy=%b occ=%0d stall=%0d ctrl=%h, required size=%0d stall=%0d ctrl=%h",
                     i, out_valid, in_ready, occupancy, stall_cycles, out_ctrl, q.size(), m_stall,
                     (q.size() > 0) ? q[0].c : 16'h0);
         end
         if (in_valid && in_ready) pushed++;
         if (out_valid && out_ready) popped++;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (pushed - popped !== q.size()) begin
         errors++;
         $display("FAIL conservation: pushed-popped=%0d, required %0d", pushed - popped, q.size());
      end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 16'h0BAD; in_data = rand_data();
      tick();
      in_valid = 1'b0;
      repeat (70000) tick();
      checks++;
      if (stall_cycles !== 16'hFFFF || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL saturate: stall=%h v=%b, required ffff/1", stall_cycles, out_valid);
      end
      repeat (5) tick();
      checks++;
      if (stall_cycles !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturate_hold: stall=%h, required ffff", stall_cycles);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      while (q.size() < 2) begin
         in_valid = 1'b1; in_ctrl = 16'($urandom) | 16'h1; in_data = rand_data();
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (occupancy !== 2'd2) begin
         errors++;
         $display("FAIL pre_async: occ=%0d, required 2", occupancy);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || stall_cycles !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: v=%b ctrl=%h occ=%0d stall=%0d rdy=%b, required 0/0/0/0/1",
                  out_valid, out_ctrl, occupancy, stall_cycles, in_ready);
      end
      q.delete();
      m_stall = 0;
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 16'h5A5A; in_data = rand_data();
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 16'h5A5A || occupancy !== 2'd1) begin
         errors++;
         $display("FAIL post_reset_fire: v=%b ctrl=%h occ=%0d, required 1/5a5a/1", out_valid, out_ctrl, occupancy);
      end
   endtask

   initial begin
      test_reset();
      test_first();
      test_back_to_back();
      test_flush();
      test_random();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one datapath word.
REQ-002 Parameter NUM_WORDS, default 5: number of datapath words carried (PC, PC+4, imm, operands, ...).
REQ-003 Parameter CTRL_WIDTH, default 16: width of packed control bundle (RegWrite, MemWrite, Branch, ...).
REQ-004 Parameter CNT_WIDTH, default 16: width of stall-cycle counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous assert, active-low (rst=0 resets); released synchronously to clk by the system.
REQ-007 in_valid  input  1  upstream stage presents a valid instruction.
REQ-008 in_ready  output  1  block can accept an instruction this cycle.
REQ-009 in_ctrl  input  CTRL_WIDTH  upstream control bundle.
REQ-010 in_data  input  NUM_WORDS*DATA_WIDTH  upstream datapath words, word 0 in LSBs.
REQ-011 flush  input  1  synchronous kill of all held and incoming instructions (branch mispredict/jump).
REQ-012 out_valid  output  1  downstream instruction valid.
REQ-013 out_ready  input  1  downstream stage accepts this cycle.
REQ-014 out_ctrl  output  CTRL_WIDTH  downstream control bundle.
REQ-015 out_data  output  NUM_WORDS*DATA_WIDTH  downstream datapath words.
REQ-016 occupancy  output  2  number of held entries (0, 1, 2).
REQ-017 stall_cycles  output  CNT_WIDTH  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-018 Block SHALL be a 2-entry skid buffer: main entry drives out_*, skid entry holds overflow; states EMPTY, ONE, TWO.
REQ-019 Input fire = in_valid & in_ready; output fire = out_valid & out_ready; both evaluated at the same edge.
REQ-020 in_ready SHALL be a registered signal equal to (state != TWO); no combinational path from out_ready to in_ready.
REQ-021 out_valid SHALL be 1 exactly in states ONE and TWO.
REQ-022 EMPTY: input fire -> load main, go ONE; else stay; latency in->out is exactly 1 cycle.
REQ-023 ONE: input & output fire -> load main with new entry, stay ONE; input only -> load skid, go TWO; output only -> go EMPTY; neither -> hold.
REQ-024 TWO: output fire -> move skid to main, go ONE; else hold; no input accepted.
REQ-025 Ordering SHALL be strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-026 flush=1 SHALL override all other events: next state EMPTY, any same-cycle input fire discarded, in_ready=1 next cycle.
REQ-027 out_ctrl SHALL be all-zero (bubble) whenever out_valid=0, including the cycle after flush; out_data may hold stale values when out_valid=0.
REQ-028 Held entries SHALL remain bit-stable while stalled (out_valid=1, out_ready=0).
REQ-029 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO, registered.
REQ-030 stall_cycles SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at all-ones, never wrap; unaffected by flush.

Reset
REQ-031 While rst=0: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid contents=0, occupancy=0, stall_cycles=0, in_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-033 First input fire is permitted on the first rising edge after rst returns to 1.

Verification
REQ-034 Reset then in_valid=1, in_ctrl=0x00A5, word0=0x1000, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x00A5, word0=0x1000, occupancy=1.
REQ-035 Stream 3 entries (ctrl 1,2,3) with out_ready=0 -> after 2 fires in_ready=0, occupancy=2, third held upstream; raise out_ready -> outputs 1,2,3 in order on consecutive cycles.
REQ-036 State TWO, assert flush one cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; flushed input never appears.
REQ-037 out_valid=1 with out_ready=0 held for 70000 cycles, CNT_WIDTH=16 -> stall_cycles=0xFFFF and stays there.
REQ-038 Drive rst=0 asynchronously between edges while occupancy=2 -> out_valid, out_ctrl, occupancy, stall_cycles all 0 before next edge.
REQ-039 Randomised in_valid/out_ready (no flush), 10000 cycles, NUM_WORDS=3, DATA_WIDTH=64 -> output sequence equals input sequence, no fire when in_ready=0.
